// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_stage
// Description : Two-stage valid/ready pipelined barrel shifter.
//               S1 captures the request (data, shift amount, op), the shift
//               is evaluated combinationally from S1, and S2 registers the
//               result. Ops: 00 SLL, 01 SRL, 11 SRA, 10 PASS.
//               Optional feature macro: SHIFT_STAGE_SRA_EN
//                 defined   -> op 11 is an arithmetic right shift
//                 undefined -> op 11 is a logical right shift (no sign fill)
//               out_count counts results accepted downstream (wraps at 16b).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_stage #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_shamt,
    input  logic [1:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic [15:0]          out_count
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_PASS = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

    // Stage 1: captured request
    logic                 s1_valid_q, s1_valid_d;
    logic [N-1:0]         s1_data_q,  s1_data_d;
    logic [$clog2(N)-1:0] s1_shamt_q, s1_shamt_d;
    logic [1:0]           s1_op_q,    s1_op_d;

    // Stage 2: registered result
    logic                 s2_valid_q, s2_valid_d;
    logic [N-1:0]         s2_data_q,  s2_data_d;

    // Accepted-result counter
    logic [15:0]          count_q,    count_d;

    // Handshake / flow-control terms
    logic                 s2_load;
    logic                 s1_adv;
    logic                 in_accept;
    logic                 out_accept;
    logic [N-1:0]         shift_res;

    // S2 can take a new value when empty or when its current result leaves.
    // in_ready is deliberately combinational from out_ready so a full
    // pipeline can move and accept a new request on the same edge.
    always_comb begin
        s2_load    = !s2_valid_q || out_ready;
        s1_adv     = s1_valid_q && s2_load;
        in_ready   = !rst && (!s1_valid_q || s1_adv);
        in_accept  = in_valid && in_ready;
        out_accept = s2_valid_q && out_ready;
    end

    // Shift evaluation between S1 and S2; bits shifted out are dropped.
    always_comb begin
        shift_res = s1_data_q;
        case (s1_op_q)
            OP_SLL:  shift_res = s1_data_q << s1_shamt_q;
            OP_SRL:  shift_res = s1_data_q >> s1_shamt_q;
`ifdef SHIFT_STAGE_SRA_EN
            OP_SRA:  shift_res = $unsigned($signed(s1_data_q) >>> s1_shamt_q);
`else
            OP_SRA:  shift_res = s1_data_q >> s1_shamt_q;
`endif
            OP_PASS: shift_res = s1_data_q;
            default: shift_res = s1_data_q;
        endcase
    end

    // Next-state for both pipeline stages and the result counter.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_shamt_d = s1_shamt_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        count_d    = count_q;

        if (in_accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_data;
            s1_shamt_d = in_shamt;
            s1_op_d    = in_op;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            s2_data_d = shift_res;
        end

        if (out_accept) begin
            count_d = count_q + 16'd1;
        end
    end

    // State registers; reset discards every in-flight request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_shamt_q <= '0;
            s1_op_q    <= OP_SLL;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            count_q    <= 16'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_shamt_q <= s1_shamt_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            count_q    <= count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_stage
// Description : Directed self-checking bench for shift_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_stage;

    localparam int N = 32;
    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_PASS = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

`ifdef SHIFT_STAGE_SRA_EN
    localparam logic [31:0] SRA_EXP = 32'hF800_000F;
`else
    localparam logic [31:0] SRA_EXP = 32'h0800_000F;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] out_count;

    int n_vec  = 0;
    int n_miss = 0;

    shift_stage #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge; in_ready must be high.
    task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_op    = o;
        chk_val("issue_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a result and consume it.
    task automatic expect_out(input string tag, input logic [31:0] exp);
        int k;
        out_ready = 1'b1;
        k = 0;
        while (!out_valid && k < 8) begin
            step();
            k++;
        end
        if (!out_valid) begin
            chk_val({tag, "_timeout"}, {31'd0, out_valid}, 32'd1);
        end else begin
            chk_val(tag, out_data, exp);
            step();
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = OP_SLL;
        out_ready = 1'b1;
        step();
        step();

        // Reset state
        chk_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk_val("rst_out_data",  out_data, 32'd0);
        chk_val("rst_out_count", {16'd0, out_count}, 32'd0);
        chk_val("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk_val("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single SLL with latency check
        issue(32'h0000_0001, 5'd31, OP_SLL);
        chk_val("sll_lat_t1", {31'd0, out_valid}, 32'd0);
        step();
        chk_val("sll_lat_t2", {31'd0, out_valid}, 32'd1);
        chk_val("sll_data", out_data, 32'h8000_0000);
        step();
        chk_val("sll_count", {16'd0, out_count}, 32'd1);
        chk_val("sll_drained", {31'd0, out_valid}, 32'd0);

        // SRL vs SRA, PASS ignores shamt, shamt 0 is identity
        issue(32'h8000_00F0, 5'd4, OP_SRL);
        expect_out("srl", 32'h0800_000F);
        issue(32'h8000_00F0, 5'd4, OP_SRA);
        expect_out("sra", SRA_EXP);
        issue(32'h1234_5678, 5'd5, OP_PASS);
        expect_out("pass", 32'h1234_5678);
        issue(32'hDEAD_BEEF, 5'd0, OP_SLL);
        expect_out("sll0", 32'hDEAD_BEEF);
        issue(32'h0000_00FF, 5'd28, OP_SLL);
        expect_out("sll_drop", 32'hF000_0000);
        step();
        chk_val("count_after_singles", {16'd0, out_count}, 32'd6);

        // Back-to-back stream of 8 PASS requests
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            in_shamt = 5'd3;
            in_op    = OP_PASS;
            chk_val($sformatf("stream_ready%0d", i), {31'd0, in_ready}, 32'd1);
            step();
            if (i >= 1) begin
                chk_val($sformatf("stream_v%0d", i - 1), {31'd0, out_valid}, 32'd1);
                chk_val($sformatf("stream_d%0d", i - 1), out_data, i - 1);
            end
        end
        in_valid = 1'b0;
        step();
        chk_val("stream_v7", {31'd0, out_valid}, 32'd1);
        chk_val("stream_d7", out_data, 32'd7);
        step();
        chk_val("stream_count", {16'd0, out_count}, 32'd14);
        chk_val("stream_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: third request must stall until release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_PASS;
        in_data   = 32'hA0;
        chk_val("bp_ready0", {31'd0, in_ready}, 32'd1);
        step();
        in_data = 32'hA1;
        chk_val("bp_ready1", {31'd0, in_ready}, 32'd1);
        step();
        in_data = 32'hA2;
        for (int c = 0; c < 5; c++) begin
            chk_val("bp_stall_ready", {31'd0, in_ready}, 32'd0);
            chk_val("bp_stall_valid", {31'd0, out_valid}, 32'd1);
            chk_val("bp_stall_data", out_data, 32'hA0);
            step();
        end
        chk_val("bp_stall_count", {16'd0, out_count}, 32'd14);
        out_ready = 1'b1;
        #1;
        chk_val("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk_val("bp_out1", out_data, 32'hA1);
        step();
        chk_val("bp_out2", out_data, 32'hA2);
        chk_val("bp_out2_v", {31'd0, out_valid}, 32'd1);
        step();
        chk_val("bp_no_dup", {31'd0, out_valid}, 32'd0);
        chk_val("bp_count", {16'd0, out_count}, 32'd17);

        // Reset mid-stream with two items in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hB0;
        step();
        in_data = 32'hB1;
        step();
        in_valid = 1'b0;
        chk_val("mid_full", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk_val("mid_rst_count", {16'd0, out_count}, 32'd0);
        chk_val("mid_rst_data", out_data, 32'd0);
        chk_val("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_val("mid_no_stale", {31'd0, out_valid}, 32'd0);
        end
        chk_val("mid_ready", {31'd0, in_ready}, 32'd1);

        // out_count wrap after 65536 accepted results
        out_ready = 1'b1;
        in_op     = OP_PASS;
        for (int i = 0; i < 65536; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            step();
        end
        in_valid = 1'b0;
        step();
        chk_val("wrap_ffff", {16'd0, out_count}, 32'h0000_FFFF);
        chk_val("wrap_last_data", out_data, 32'd65535);
        step();
        chk_val("wrap_zero", {16'd0, out_count}, 32'd0);
        chk_val("wrap_drained", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
